// File: rtl/tc_pkg.sv
// Shared tensor-core definitions: datapath widths, FP16 encoding constants and
// the drain-side state type.
package tc_pkg;

   localparam int DWIDTH    = 16;
   localparam int AWIDTH    = 91;
   localparam int FRAC_BITS = 48;

   localparam int EXP_W = 5;
   localparam int MAN_W = 10;
   localparam int BIAS  = 15;

   localparam logic [DWIDTH-1:0] FP16_PINF = 16'h7C00;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

endpackage : tc_pkg

// File: rtl/tc_result_drain_kulisch_to_fp16.sv
// Combinational Kulisch accumulator to FP16 converter, round-to-nearest-even,
// saturating to infinity and never producing NaN or -0.
module kulisch_to_fp16
   import tc_pkg::*;
(
   input  logic [AWIDTH-1:0] acc_i,
   output logic [DWIDTH-1:0] fp_o
);

   localparam int PW         = $clog2(AWIDTH);
   localparam int NORM_MIN_P = FRAC_BITS - (BIAS - 1);      // leading-one position of 2^-14
   localparam int OVF_P      = FRAC_BITS + BIAS + 1;        // leading-one position of 2^16
   localparam int SUB_LSB    = NORM_MIN_P - MAN_W;          // bit weighted 2^-24

   logic                    sign;
   logic [AWIDTH-1:0]       mag;
   logic [PW-1:0]           lead_p;
   logic [PW-1:0]           shamt;
   logic [AWIDTH-2:0]       norm;
   logic [EXP_W+MAN_W-1:0]  base;
   logic [EXP_W+MAN_W-1:0]  rounded;
   logic                    guard;
   logic                    sticky;
   logic                    round_up;

   // NOTE: combinational logic uses blocking assignments and gives every
   // variable a default first, so no latch can be inferred.
   always_comb begin
      sign   = acc_i[AWIDTH-1];
      mag    = sign ? -acc_i : acc_i;
      lead_p = '0;
      for (int i = 0; i < AWIDTH; i++) begin
         if (mag[i]) lead_p = PW'(i);
      end
      shamt = PW'(AWIDTH - 1) - lead_p;
      norm  = (AWIDTH-1)'(mag << shamt);

      if (lead_p >= PW'(NORM_MIN_P)) begin
         base   = {EXP_W'(lead_p - PW'(FRAC_BITS - BIAS)), norm[AWIDTH-2 -: MAN_W]};
         guard  = norm[AWIDTH-2-MAN_W];
         sticky = |norm[AWIDTH-3-MAN_W:0];
      end else begin
         // Subnormal: fixed quantum of 2^-24; a carry out lands on 16'h0400.
         base   = {EXP_W'(0), mag[SUB_LSB+MAN_W-1:SUB_LSB]};
         guard  = mag[SUB_LSB-1];
         sticky = |mag[SUB_LSB-2:0];
      end

      round_up = guard & (sticky | base[0]);
      rounded  = base + (EXP_W+MAN_W)'(round_up);

      if (mag == '0 || rounded == '0) begin
         fp_o = '0;
      end else if (lead_p >= PW'(OVF_P) || rounded[EXP_W+MAN_W-1:MAN_W] == '1) begin
         fp_o = {sign, FP16_PINF[DWIDTH-2:0]};
      end else begin
         fp_o = {sign, rounded};
      end
   end

endmodule : kulisch_to_fp16

// File: rtl/tc_result_drain.sv
// Captures one 4x4 accumulator tile and streams it row-major as FP16 over a
// valid/ready port, one element per accepted beat.
module tc_result_drain
   import tc_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,      // asynchronous, active-high
   input  logic [0:3][0:3][AWIDTH-1:0]   c_in,
   input  logic                          c_valid,
   output logic                          c_ready,
   output logic [DWIDTH-1:0]             out_data,
   output logic [1:0]                    out_row,
   output logic [1:0]                    out_col,
   output logic                          out_last,
   output logic                          out_valid,
   input  logic                          out_ready
);

   drain_state_t              state_q, state_d;
   logic [3:0]                idx_q, idx_d;
   logic                      c_ready_q, c_ready_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic [DWIDTH-1:0]         out_data_q, out_data_d;
   logic [0:15][AWIDTH-1:0]   buf_q;

   logic                      capture;
   logic                      handshake;
   logic [3:0]                idx_inc;
   logic [AWIDTH-1:0]         conv_in;
   logic [DWIDTH-1:0]         conv_out;

   assign capture   = c_valid && c_ready_q;
   assign handshake = out_valid_q && out_ready;
   assign idx_inc   = idx_q + 4'd1;

   // In IDLE the converter looks straight at element (0,0) so it can be
   // registered on the capture edge; in DRAIN it pre-converts the next element.
   assign conv_in = (state_q == IDLE) ? c_in[0][0] : buf_q[idx_inc];

   kulisch_to_fp16 u_conv (
      .acc_i (conv_in),
      .fp_o  (conv_out)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      c_ready_d   = c_ready_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               state_d     = DRAIN;
               idx_d       = 4'd0;
               c_ready_d   = 1'b0;
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               out_data_d  = conv_out;
            end
         end
         DRAIN: begin
            if (handshake) begin
               if (idx_q == 4'd15) begin
                  state_d     = IDLE;
                  idx_d       = 4'd0;
                  c_ready_d   = 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  idx_d      = idx_inc;
                  out_last_d = (idx_inc == 4'd15);
                  out_data_d = conv_out;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         c_ready_q   <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         c_ready_q   <= c_ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // NOTE: the tile buffer is plain storage with no reset; it is only read
   // after a capture has overwritten it.
   always_ff @(posedge clk) begin
      if (capture) buf_q <= c_in;
   end

   assign c_ready   = c_ready_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;
   assign out_row   = idx_q[3:2];
   assign out_col   = idx_q[1:0];

endmodule : tc_result_drain

// File: tb/tb_tc_result_drain.sv
// Directed bench for tc_result_drain: tile streaming, back-pressure, FP16
// rounding/overflow corners, input blocking during drain and mid-drain reset.
module tb_tc_result_drain;
   import tc_pkg::*;

   typedef logic [0:3][0:3][AWIDTH-1:0] tile_t;
   typedef logic [0:15][AWIDTH-1:0]     flat_t;
   typedef logic [0:15][DWIDTH-1:0]     exp_t;

   localparam logic [AWIDTH-1:0] ONE = 1;

   logic              clk = 1'b0;
   logic              rst_n;
   tile_t             c_in;
   logic              c_valid;
   logic              c_ready;
   logic [DWIDTH-1:0] out_data;
   logic [1:0]        out_row;
   logic [1:0]        out_col;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   int errors = 0;
   int checks = 0;

   flat_t f1, f2, f3;
   exp_t  e1, e2, e3;

   tc_result_drain dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c_in      (c_in),
      .c_valid   (c_valid),
      .c_ready   (c_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic capture(input flat_t t, input bit hold);
      int cyc = 0;
      c_in    = t;
      c_valid = 1'b1;
      while (!c_ready && cyc < 50) begin
         tick();
         cyc++;
      end
      check("c_ready_wait", 16'(c_ready), 16'(1));
      tick();
      if (!hold) c_valid = 1'b0;
      check("first_valid", 16'(out_valid), 16'(1));
   endtask

   task automatic drain(input exp_t e, input int stop_at, input bit rnd);
      int         n = 0;
      int         cyc = 0;
      bit         stalled = 1'b0;
      logic [15:0] held_d = '0;
      logic [3:0]  held_idx = '0;
      while (n < stop_at && cyc < 400) begin
         if (stalled) begin
            check("hold_data", out_data, held_d);
            check("hold_pos", 16'({out_row, out_col}), 16'(held_idx));
            check("hold_valid", 16'(out_valid), 16'(1));
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled   = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               check("data", out_data, e[4'(n)]);
               check("pos", 16'({out_row, out_col}), 16'(n));
               check("last", 16'(out_last), 16'(n == 15));
               check("c_ready_busy", 16'(c_ready), 16'(0));
               n++;
            end else begin
               stalled  = 1'b1;
               held_d   = out_data;
               held_idx = {out_row, out_col};
            end
         end
         tick();
         cyc++;
      end
      out_ready = 1'b0;
      check("beats", 16'(n), 16'(stop_at));
      if (stop_at == 16) begin
         check("idle_valid", 16'(out_valid), 16'(0));
         check("idle_ready", 16'(c_ready), 16'(1));
      end
   endtask

   initial begin
      f1 = '0;
      f1[0] = ONE << 48;
      f1[1] = -(AWIDTH'(5) << 47);
      e1 = '0;
      e1[0] = 16'h3C00;
      e1[1] = 16'hC100;

      for (int i = 0; i < 16; i++) f2[4'(i)] = AWIDTH'(i + 1) << 48;
      e2 = {16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
            16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};

      f3[0]  = (ONE << 48) | (ONE << 37);              // 1+2^-11, tie to even
      f3[1]  = (ONE << 48) | (AWIDTH'(3) << 37);       // 1+3*2^-11, tie rounds up
      f3[2]  = ONE << 24;                              // 2^-24
      f3[3]  = ONE << 23;                              // 2^-25
      f3[4]  = AWIDTH'(3) << 23;                       // 3*2^-25
      f3[5]  = AWIDTH'(16'hFFE0) << 48;                // 65504
      f3[6]  = AWIDTH'(16'hFFF0) << 48;                // 65520
      f3[7]  = -(ONE << 68);                           // -2^20
      f3[8]  = ONE << 90;                              // most-negative accumulator
      f3[9]  = -(ONE << 23);                           // -2^-25, no -0
      f3[10] = ONE << 34;                              // 2^-14
      f3[11] = (ONE << 34) - (ONE << 23);              // rounds up to 2^-14
      f3[12] = ONE << 64;                              // 2^16
      f3[13] = -(AWIDTH'(3) << 47);                    // -1.5
      f3[14] = AWIDTH'(5) << 22;                       // 1.25*2^-24
      f3[15] = ONE << 47;                              // 0.5
      e3 = {16'h3C00, 16'h3C02, 16'h0001, 16'h0000, 16'h0002, 16'h7BFF, 16'h7C00, 16'hFC00,
            16'hFC00, 16'h0000, 16'h0400, 16'h0400, 16'h7C00, 16'hBE00, 16'h0001, 16'h3800};

      rst_n     = 1'b0;
      c_in      = '0;
      c_valid   = 1'b0;
      out_ready = 1'b0;
      #1 rst_n  = 1'b1;
      repeat (3) tick();
      check("rst_c_ready", 16'(c_ready), 16'(1));
      check("rst_out_valid", 16'(out_valid), 16'(0));
      check("rst_out_last", 16'(out_last), 16'(0));
      check("rst_out_data", out_data, 16'h0000);
      check("rst_pos", 16'({out_row, out_col}), 16'(0));
      rst_n = 1'b0;
      tick();

      // Basic tile, full throughput.
      capture(f1, 1'b0);
      drain(e1, 16, 1'b0);

      // 1.0 .. 16.0 under random back-pressure.
      capture(f2, 1'b0);
      drain(e2, 16, 1'b1);

      // Rounding and overflow corners.
      capture(f3, 1'b0);
      drain(e3, 16, 1'b0);

      // c_valid held through the drain with a different tile on c_in.
      capture(f1, 1'b1);
      c_in = f2;
      drain(e1, 16, 1'b0);
      tick();
      c_valid = 1'b0;
      check("second_capture_valid", 16'(out_valid), 16'(1));
      drain(e2, 16, 1'b0);

      // Reset at element 7 of a drain.
      capture(f2, 1'b0);
      drain(e2, 7, 1'b0);
      check("pre_reset_pos", 16'({out_row, out_col}), 16'(7));
      rst_n = 1'b1;
      #1;
      check("mid_rst_valid", 16'(out_valid), 16'(0));
      check("mid_rst_c_ready", 16'(c_ready), 16'(1));
      check("mid_rst_pos", 16'({out_row, out_col}), 16'(0));
      tick();
      rst_n = 1'b0;
      tick();
      check("post_rst_valid", 16'(out_valid), 16'(0));
      capture(f3, 1'b0);
      drain(e3, 16, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_tc_result_drain
